// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: latches a masked parallel word and shifts it out MSB-first,
// one bit per clock, with gapless back-to-back frames and a synchronous abort.
// Optional macro SEQ_PATTERN_GEN_LFSR_FILL_EN: don't-care bits come from an internal
// maximal-length Fibonacci LFSR (seed all-ones, one step per accepted frame) instead of fill.
module seq_pattern_gen #(
  parameter int unsigned LEN   = 9,
  parameter int unsigned CNT_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [LEN-1:0] pat,
  input  logic [LEN-1:0] care,
  input  logic [LEN-1:0] fill,
  input  logic           abort,
  output logic           ready,
  output logic           a,
  output logic           a_vld,
  output logic           done
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  localparam logic [CNT_W-1:0] LastCnt   = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] LastCntM1 = CNT_W'(LEN - 2);

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [LEN-1:0]   r_shift, w_shift_d;
  logic             r_a, w_a_d;
  logic             r_a_vld, w_a_vld_d;
  logic             r_done, w_done_d;

  logic             w_last;
  logic             w_accept;
  logic [LEN-1:0]   w_fill_src;
  logic [LEN-1:0]   w_word;

  assign w_last   = (r_state == StSend) && (r_cnt == LastCnt);
  assign ready    = ((r_state == StIdle) || w_last) && !abort;
  assign w_accept = start && ready;

`ifdef SEQ_PATTERN_GEN_LFSR_FILL_EN
  // Feedback tap masks (bit t-1 set for tap x^t) for maximal-length polynomials.
  function automatic logic [31:0] taps_for(input int unsigned n);
    logic [31:0] m;
    m = 32'h0;
    case (n)
      2:       m = 32'h0000_0003;
      3:       m = 32'h0000_0006;
      4:       m = 32'h0000_000C;
      5:       m = 32'h0000_0014;
      6:       m = 32'h0000_0030;
      7:       m = 32'h0000_0060;
      8:       m = 32'h0000_00B8;
      9:       m = 32'h0000_0110;
      10:      m = 32'h0000_0240;
      11:      m = 32'h0000_0500;
      12:      m = 32'h0000_0829;
      13:      m = 32'h0000_100D;
      14:      m = 32'h0000_2015;
      15:      m = 32'h0000_6000;
      16:      m = 32'h0000_D008;
      17:      m = 32'h0001_2000;
      18:      m = 32'h0002_0400;
      19:      m = 32'h0004_0023;
      20:      m = 32'h0009_0000;
      21:      m = 32'h0014_0000;
      22:      m = 32'h0030_0000;
      23:      m = 32'h0042_0000;
      24:      m = 32'h00E1_0000;
      25:      m = 32'h0120_0000;
      26:      m = 32'h0200_0023;
      27:      m = 32'h0400_0013;
      28:      m = 32'h0900_0000;
      29:      m = 32'h1400_0000;
      30:      m = 32'h2000_0029;
      31:      m = 32'h4800_0000;
      32:      m = 32'h8020_0003;
      default: m = 32'h0;
    endcase
    return m;
  endfunction

  localparam logic [31:0]    TapsAll = taps_for(LEN);
  localparam logic [LEN-1:0] Taps    = TapsAll[LEN-1:0];

  logic [LEN-1:0] r_lfsr;
  logic           w_lfsr_fb;
  logic           w_unused_fill;

  assign w_lfsr_fb     = ^(r_lfsr & Taps);
  assign w_unused_fill = ^fill;
  // Pre-step value fills the frame being accepted.
  assign w_fill_src    = r_lfsr;

  // LFSR steps once per accepted frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= '1;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[LEN-2:0], w_lfsr_fb};
    end
  end
`else
  assign w_fill_src = fill;
`endif

  assign w_word = (pat & care) | (w_fill_src & ~care);

  // Next-state: load on acceptance, shift while sending, otherwise fall back to idle.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_shift_d = r_shift;
    w_a_d     = 1'b0;
    w_a_vld_d = 1'b0;
    w_done_d  = 1'b0;
    if (w_accept) begin
      // First bit goes straight to the output register; the rest wait in the shifter.
      w_state_d = StSend;
      w_cnt_d   = '0;
      w_shift_d = {w_word[LEN-2:0], 1'b0};
      w_a_d     = w_word[LEN-1];
      w_a_vld_d = 1'b1;
    end else if ((r_state == StSend) && !abort && !w_last) begin
      w_cnt_d   = r_cnt + CNT_W'(1);
      w_shift_d = {r_shift[LEN-2:0], 1'b0};
      w_a_d     = r_shift[LEN-1];
      w_a_vld_d = 1'b1;
      w_done_d  = (r_cnt == LastCntM1);
    end else begin
      w_state_d = StIdle;
    end
  end

  // State and registered outputs; reset kills any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_shift <= '0;
      r_a     <= 1'b0;
      r_a_vld <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_shift <= w_shift_d;
      r_a     <= w_a_d;
      r_a_vld <= w_a_vld_d;
      r_done  <= w_done_d;
    end
  end

  assign a     = r_a;
  assign a_vld = r_a_vld;
  assign done  = r_done;

endmodule
